// File: rtl/ip_bus_arbiter.sv
// Two-master round-robin arbiter for the shared 64-bit system bus.
// Define ARB_TIMEOUT_EN to add the address/data-phase watchdog.
module ip_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              m0_read_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [3:0]        m0_size_i,
  input  logic [DATA_W-1:0] m0_write_data_i,
  input  logic              m0_write_valid_i,
  output logic              m0_grant_o,
  output logic [DATA_W-1:0] m0_read_data_o,
  output logic              m0_read_valid_o,
  output logic              m0_error_o,
  input  logic              m1_read_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [3:0]        m1_size_i,
  input  logic [DATA_W-1:0] m1_write_data_i,
  input  logic              m1_write_valid_i,
  output logic              m1_grant_o,
  output logic [DATA_W-1:0] m1_read_data_o,
  output logic              m1_read_valid_o,
  output logic              m1_error_o,
  output logic              s_read_o,
  output logic              s_write_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [3:0]        s_size_o,
  output logic [DATA_W-1:0] s_write_data_o,
  output logic              s_write_valid_o,
  input  logic              s_grant_i,
  input  logic              s_read_valid_i,
  input  logic [DATA_W-1:0] s_read_data_i,
  input  logic              s_error_i,
  output logic              busy_o,
  output logic              owner_o
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state, state_nxt;
  logic              owner, last_owner, is_read;
  logic [2:0]        beats, beat_cnt;

  logic              o_read, o_write, o_wvalid;
  logic [ADDR_W-1:0] o_addr;
  logic [3:0]        o_size;
  logic [DATA_W-1:0] o_wdata;
  logic              req0, req1, arb_pick;
  logic              beat, last_beat, abort, wd_expire;
  logic              grant_gated, rvalid_gated;

  function automatic logic [2:0] size_to_beats(input logic [3:0] size);
    case (size)
      4'd8:    return 3'd2;
      4'd9:    return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  assign o_read   = owner ? m1_read_i        : m0_read_i;
  assign o_write  = owner ? m1_write_i       : m0_write_i;
  assign o_addr   = owner ? m1_addr_i        : m0_addr_i;
  assign o_size   = owner ? m1_size_i        : m0_size_i;
  assign o_wdata  = owner ? m1_write_data_i  : m0_write_data_i;
  assign o_wvalid = owner ? m1_write_valid_i : m0_write_valid_i;

  assign req0     = m0_read_i | m0_write_i;
  assign req1     = m1_read_i | m1_write_i;
  // On a tie the master that did not own the bus last time wins.
  assign arb_pick = (req0 & req1) ? ~last_owner : req1;

  assign beat      = (state == DATA) & (is_read ? s_read_valid_i : o_wvalid);
  assign last_beat = beat & (beat_cnt == beats - 3'd1);
  assign abort     = ((state != IDLE) & s_error_i) | wd_expire;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] wdog;

  // Restarts on every sign of progress: idle, grant, or a data beat.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i)
      wdog <= 8'd0;
    else if ((state == IDLE) || ((state == ADDR) && s_grant_i) || beat)
      wdog <= 8'd0;
    else
      wdog <= wdog + 8'd1;
  end

  assign wd_expire = (state != IDLE) && (wdog == TO_LIMIT);
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req0 | req1) state_nxt = ADDR;
      ADDR: begin
        if (abort)                   state_nxt = IDLE;
        else if (s_grant_i)          state_nxt = DATA;
        else if (!(o_read | o_write)) state_nxt = IDLE;
      end
      DATA: if (abort | last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      owner      <= 1'b0;
      last_owner <= 1'b1;
      is_read    <= 1'b0;
      beats      <= 3'd1;
      beat_cnt   <= 3'd0;
    end else begin
      if ((state == IDLE) && (req0 | req1))
        owner <= arb_pick;
      if ((state == ADDR) && s_grant_i && !abort) begin
        is_read  <= o_read;
        beats    <= size_to_beats(o_size);
        beat_cnt <= 3'd0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + 3'd1;
      end
      if (abort | last_beat)
        last_owner <= owner;
    end
  end

  always_comb begin
    s_read_o        = 1'b0;
    s_write_o       = 1'b0;
    s_write_valid_o = 1'b0;
    grant_gated     = 1'b0;
    rvalid_gated    = 1'b0;
    s_addr_o        = o_addr;
    s_size_o        = o_size;
    s_write_data_o  = o_wdata;
    case (state)
      ADDR: begin
        s_read_o    = o_read;
        s_write_o   = o_write & ~o_read;
        grant_gated = s_grant_i;
      end
      DATA: begin
        s_write_valid_o = ~is_read & o_wvalid;
        rvalid_gated    = is_read & s_read_valid_i;
      end
      default: ;
    endcase
    m0_grant_o      = grant_gated  & ~owner;
    m1_grant_o      = grant_gated  &  owner;
    m0_read_valid_o = rvalid_gated & ~owner;
    m1_read_valid_o = rvalid_gated &  owner;
    m0_error_o      = abort & ~owner;
    m1_error_o      = abort &  owner;
    m0_read_data_o  = s_read_data_i;
    m1_read_data_o  = s_read_data_i;
    busy_o          = (state != IDLE);
    owner_o         = owner;
  end

endmodule

// File: tb/tb_ip_bus_arbiter.sv
// Directed bench for ip_bus_arbiter; the bench plays both masters and the slave.
module tb_ip_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        m0_rd, m0_wr, m0_wv, m1_rd, m1_wr, m1_wv;
  logic [31:0] m0_addr, m1_addr;
  logic [3:0]  m0_size, m1_size;
  logic [63:0] m0_wd, m1_wd;
  logic        m0_gnt, m0_rv, m0_err, m1_gnt, m1_rv, m1_err;
  logic [63:0] m0_rdata, m1_rdata;
  logic        s_rd, s_wr, s_wv, s_gnt, s_rv, s_err;
  logic [31:0] s_addr;
  logic [3:0]  s_size;
  logic [63:0] s_wd, s_rdata;
  logic        busy, owner;

  int vecs = 0;
  int errs = 0;

  ip_bus_arbiter #(.ADDR_W(32), .DATA_W(64), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .m0_read_i(m0_rd), .m0_write_i(m0_wr), .m0_addr_i(m0_addr), .m0_size_i(m0_size),
    .m0_write_data_i(m0_wd), .m0_write_valid_i(m0_wv), .m0_grant_o(m0_gnt),
    .m0_read_data_o(m0_rdata), .m0_read_valid_o(m0_rv), .m0_error_o(m0_err),
    .m1_read_i(m1_rd), .m1_write_i(m1_wr), .m1_addr_i(m1_addr), .m1_size_i(m1_size),
    .m1_write_data_i(m1_wd), .m1_write_valid_i(m1_wv), .m1_grant_o(m1_gnt),
    .m1_read_data_o(m1_rdata), .m1_read_valid_o(m1_rv), .m1_error_o(m1_err),
    .s_read_o(s_rd), .s_write_o(s_wr), .s_addr_o(s_addr), .s_size_o(s_size),
    .s_write_data_o(s_wd), .s_write_valid_o(s_wv), .s_grant_i(s_gnt),
    .s_read_valid_i(s_rv), .s_read_data_i(s_rdata), .s_error_i(s_err),
    .busy_o(busy), .owner_o(owner)
  );

  task automatic idle_inputs;
    m0_rd = 0; m0_wr = 0; m0_wv = 0; m0_addr = 0; m0_size = 0; m0_wd = 0;
    m1_rd = 0; m1_wr = 0; m1_wv = 0; m1_addr = 0; m1_size = 0; m1_wd = 0;
    s_gnt = 0; s_rv = 0; s_err = 0; s_rdata = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 0;
    @(negedge clk); @(negedge clk); #1;
    vecs++; if (busy !== 1'b0)     begin errs++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    vecs++; if (owner !== 1'b0)    begin errs++; $display("FAIL rst_owner got=%0b exp=0", owner); end
    vecs++; if ({m0_gnt, m1_gnt, m0_rv, m1_rv, m0_err, m1_err} !== 6'b0)
      begin errs++; $display("FAIL rst_master_outs got=%b exp=000000", {m0_gnt, m1_gnt, m0_rv, m1_rv, m0_err, m1_err}); end
    vecs++; if ({s_rd, s_wr, s_wv} !== 3'b0) begin errs++; $display("FAIL rst_s_ctrl got=%b exp=000", {s_rd, s_wr, s_wv}); end
    vecs++; if (s_addr !== 32'h0)  begin errs++; $display("FAIL rst_s_addr got=%h exp=0", s_addr); end
    rst_n = 1;
  endtask

  task automatic test_round_robin;
    @(negedge clk);
    m0_rd = 1; m0_addr = 32'd8;  m0_size = 4'd3;
    m1_rd = 1; m1_addr = 32'd16; m1_size = 4'd3;
    #1;
    vecs++; if (s_rd !== 1'b0) begin errs++; $display("FAIL rr_latency s_read got=%0b exp=0", s_rd); end
    @(negedge clk); #1;
    vecs++; if (owner !== 1'b0)    begin errs++; $display("FAIL rr_first_owner got=%0b exp=0", owner); end
    vecs++; if (s_addr !== 32'd8)  begin errs++; $display("FAIL rr_first_addr got=%0d exp=8", s_addr); end
    vecs++; if (s_rd !== 1'b1)     begin errs++; $display("FAIL rr_first_s_read got=%0b exp=1", s_rd); end
    s_gnt = 1; #1;
    vecs++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errs++; $display("FAIL rr_first_grant got=%b exp=10", {m0_gnt, m1_gnt}); end
    @(negedge clk);
    s_gnt = 0; m0_rd = 0; s_rv = 1; s_rdata = 64'h1111; #1;
    vecs++; if ({m0_rv, m1_rv} !== 2'b10) begin errs++; $display("FAIL rr_first_rvalid got=%b exp=10", {m0_rv, m1_rv}); end
    vecs++; if (s_rd !== 1'b0)     begin errs++; $display("FAIL rr_data_s_read got=%0b exp=0", s_rd); end
    @(negedge clk);
    s_rv = 0; m0_rd = 1; m0_addr = 32'd24; #1;
    vecs++; if (busy !== 1'b0)     begin errs++; $display("FAIL rr_dead_cycle busy got=%0b exp=0", busy); end
    @(negedge clk); #1;
    vecs++; if (owner !== 1'b1)    begin errs++; $display("FAIL rr_second_owner got=%0b exp=1", owner); end
    vecs++; if (s_addr !== 32'd16) begin errs++; $display("FAIL rr_second_addr got=%0d exp=16", s_addr); end
    s_gnt = 1; #1;
    vecs++; if ({m0_gnt, m1_gnt} !== 2'b01) begin errs++; $display("FAIL rr_second_grant got=%b exp=01", {m0_gnt, m1_gnt}); end
    @(negedge clk);
    s_gnt = 0; m1_rd = 0; s_rv = 1; s_rdata = 64'h2222; #1;
    vecs++; if ({m0_rv, m1_rv} !== 2'b01) begin errs++; $display("FAIL rr_second_rvalid got=%b exp=01", {m0_rv, m1_rv}); end
    vecs++; if (m1_rdata !== 64'h2222) begin errs++; $display("FAIL rr_second_rdata got=%h exp=2222", m1_rdata); end
    @(negedge clk);
    s_rv = 0; #1;
    @(negedge clk); #1;
    vecs++; if (owner !== 1'b0)    begin errs++; $display("FAIL rr_third_owner got=%0b exp=0", owner); end
    vecs++; if (s_addr !== 32'd24) begin errs++; $display("FAIL rr_third_addr got=%0d exp=24", s_addr); end
    s_gnt = 1;
    @(negedge clk);
    s_gnt = 0; m0_rd = 0; s_rv = 1; #1;
    vecs++; if (m0_rv !== 1'b1)    begin errs++; $display("FAIL rr_third_rvalid got=%0b exp=1", m0_rv); end
    @(negedge clk);
    s_rv = 0; #1;
    vecs++; if (busy !== 1'b0)     begin errs++; $display("FAIL rr_end busy got=%0b exp=0", busy); end
  endtask

  task automatic test_read_burst;
    @(negedge clk);
    m0_rd = 1; m0_addr = 32'd0; m0_size = 4'd8;
    @(negedge clk); #1;
    vecs++; if (s_size !== 4'd8) begin errs++; $display("FAIL rb_s_size got=%0d exp=8", s_size); end
    s_gnt = 1;
    @(negedge clk);
    s_gnt = 0; m0_rd = 0; s_rv = 1; s_rdata = 64'h00000000ffffffff; #1;
    vecs++; if ({m0_rv, m1_rv} !== 2'b10) begin errs++; $display("FAIL rb_beat0_valid got=%b exp=10", {m0_rv, m1_rv}); end
    vecs++; if (m0_rdata !== 64'h00000000ffffffff) begin errs++; $display("FAIL rb_beat0_data got=%h exp=00000000ffffffff", m0_rdata); end
    @(negedge clk);
    s_rdata = 64'hffffffff00000000; #1;
    vecs++; if ({m0_rv, m1_rv, busy} !== 3'b101) begin errs++; $display("FAIL rb_beat1_valid_busy got=%b exp=101", {m0_rv, m1_rv, busy}); end
    vecs++; if (m0_rdata !== 64'hffffffff00000000) begin errs++; $display("FAIL rb_beat1_data got=%h exp=ffffffff00000000", m0_rdata); end
    @(negedge clk);
    s_rv = 0; #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rb_done busy got=%0b exp=0", busy); end
  endtask

  task automatic test_write_burst;
    logic exp_busy;
    @(negedge clk);
    m1_wr = 1; m1_addr = 32'd32; m1_size = 4'd9;
    @(negedge clk); #1;
    vecs++; if ({owner, s_wr, s_rd} !== 3'b110) begin errs++; $display("FAIL wb_addr_phase got=%b exp=110", {owner, s_wr, s_rd}); end
    vecs++; if (s_addr !== 32'd32) begin errs++; $display("FAIL wb_s_addr got=%0d exp=32", s_addr); end
    s_gnt = 1; #1;
    vecs++; if ({m0_gnt, m1_gnt} !== 2'b01) begin errs++; $display("FAIL wb_grant got=%b exp=01", {m0_gnt, m1_gnt}); end
    @(negedge clk);
    s_gnt = 0; m1_wr = 0; m0_wd = 64'hdead; #1;
    vecs++; if ({s_wr, s_wv} !== 2'b00) begin errs++; $display("FAIL wb_data_ctrl got=%b exp=00", {s_wr, s_wv}); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      m1_wv = 1; m1_wd = 64'ha0 + 64'(k); m0_wv = (k % 2) == 1; #1;
      vecs++; if (s_wv !== 1'b1) begin errs++; $display("FAIL wb_beat%0d_valid got=%0b exp=1", k, s_wv); end
      vecs++; if (s_wd !== 64'ha0 + 64'(k)) begin errs++; $display("FAIL wb_beat%0d_data got=%h exp=%h", k, s_wd, 64'ha0 + 64'(k)); end
      @(negedge clk);
      m1_wv = 0; m0_wv = 1; exp_busy = (k < 3); #1;
      vecs++; if (s_wv !== 1'b0) begin errs++; $display("FAIL wb_gap%0d_valid got=%0b exp=0", k, s_wv); end
      vecs++; if (busy !== exp_busy) begin errs++; $display("FAIL wb_gap%0d_busy got=%0b exp=%0b", k, busy, exp_busy); end
    end
    m0_wv = 0;
  endtask

  task automatic test_error;
    @(negedge clk);
    m0_wr = 1; m0_addr = 32'd256; m0_size = 4'd3;
    m1_rd = 1; m1_addr = 32'd40;  m1_size = 4'd3;
    @(negedge clk); #1;
    vecs++; if ({owner, s_wr} !== 2'b01) begin errs++; $display("FAIL err_owner_write got=%b exp=01", {owner, s_wr}); end
    s_err = 1; #1;
    vecs++; if ({m0_err, m1_err} !== 2'b10) begin errs++; $display("FAIL err_route got=%b exp=10", {m0_err, m1_err}); end
    @(negedge clk);
    s_err = 0; m0_wr = 0; #1;
    vecs++; if ({busy, m0_err} !== 2'b00) begin errs++; $display("FAIL err_idle got=%b exp=00", {busy, m0_err}); end
    @(negedge clk); #1;
    vecs++; if ({owner, s_rd} !== 2'b11) begin errs++; $display("FAIL err_next_owner got=%b exp=11", {owner, s_rd}); end
    vecs++; if (s_addr !== 32'd40) begin errs++; $display("FAIL err_next_addr got=%0d exp=40", s_addr); end
    s_gnt = 1; #1;
    vecs++; if (m1_gnt !== 1'b1) begin errs++; $display("FAIL err_next_grant got=%0b exp=1", m1_gnt); end
    @(negedge clk);
    s_gnt = 0; m1_rd = 0; s_rv = 1; #1;
    @(negedge clk);
    s_rv = 0; #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL err_end busy got=%0b exp=0", busy); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    m1_rd = 1; m1_addr = 32'd0; m1_size = 4'd9;
    @(negedge clk);
    s_gnt = 1;
    @(negedge clk);
    s_gnt = 0; m1_rd = 0; s_rv = 1; s_rdata = 64'h55; #1;
    vecs++; if (m1_rv !== 1'b1) begin errs++; $display("FAIL rm_beat1 got=%0b exp=1", m1_rv); end
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1; idle_inputs(); s_rv = 1; #1;
    vecs++; if ({busy, owner, m0_rv, m1_rv, m0_gnt, m1_gnt, m0_err, m1_err} !== 8'b0)
      begin errs++; $display("FAIL rm_outs got=%b exp=00000000", {busy, owner, m0_rv, m1_rv, m0_gnt, m1_gnt, m0_err, m1_err}); end
    vecs++; if ({s_rd, s_wr, s_wv} !== 3'b0) begin errs++; $display("FAIL rm_s_ctrl got=%b exp=000", {s_rd, s_wr, s_wv}); end
    @(negedge clk);
    s_rv = 0;
    m0_rd = 1; m0_addr = 32'd8;  m0_size = 4'd3;
    m1_rd = 1; m1_addr = 32'd16; m1_size = 4'd3;
    @(negedge clk); #1;
    vecs++; if ({owner, s_rd} !== 2'b01) begin errs++; $display("FAIL rm_prio got=%b exp=01", {owner, s_rd}); end
    m0_rd = 0; m1_rd = 0; #1;
    vecs++; if ({s_rd, m0_gnt} !== 2'b00) begin errs++; $display("FAIL rm_drop got=%b exp=00", {s_rd, m0_gnt}); end
    @(negedge clk); #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rm_drop_idle busy got=%0b exp=0", busy); end
  endtask

  task automatic test_watchdog;
    logic exp_err;
    @(negedge clk);
    m0_wr = 1; m0_addr = 32'd64; m0_size = 4'd9;
    @(negedge clk);
    s_gnt = 1;
    @(negedge clk);
    s_gnt = 0; m0_wr = 0; m0_wv = 1; m0_wd = 64'h77; #1;
    vecs++; if (s_wv !== 1'b1) begin errs++; $display("FAIL wd_beat got=%0b exp=1", s_wv); end
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      m0_wv = 0;
`ifdef ARB_TIMEOUT_EN
      exp_err = (i == 16);
`else
      exp_err = 1'b0;
`endif
      #1;
      vecs++; if ({busy, m0_err, m1_err} !== {1'b1, exp_err, 1'b0})
        begin errs++; $display("FAIL wd_cycle%0d got=%b exp=%b", i, {busy, m0_err, m1_err}, {1'b1, exp_err, 1'b0}); end
    end
`ifdef ARB_TIMEOUT_EN
    @(negedge clk); #1;
`else
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1; #1;
`endif
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL wd_freed busy got=%0b exp=0", busy); end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_read_burst();
    test_write_burst();
    test_error();
    test_reset_mid();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
